if_fetch_stage: RTL and testbench

- Instruction-fetch stage sitting between the PC register and the decode stage.
- Issues PC-addressed requests to instruction memory over a req/ack handshake and captures the returned word together with its PC into the IF/ID pipeline register.
- Drives pc_write back to the PC register so the PC advances only when a fetched instruction is actually accepted.
- Handles decode-stage stall, pipeline flush/redirect, and variable memory latency.

---
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 tb/tb_if_fetch_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues PC-addressed imem requests and fills the IF/ID register.
// A one-entry hold buffer absorbs decode stalls; DISCARD drains a fetch that a flush made stale.
`ifndef PC_REG_NPC
`define PC_REG_NPC 1'b1
`endif

module if_fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_write,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        flush,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_instr
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

   state_t      state_q, state_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        mem_ack;
   logic        load_mem;
   logic        load_buf;
   logic        to_buf;

   // ack is only meaningful while a request is actually on the bus
   assign mem_ack = imem_ack && ((state_q == REQ) || (state_q == DISCARD));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = REQ;
         REQ: begin
            if (flush)                    state_d = mem_ack ? REQ : DISCARD;
            else if (mem_ack && id_stall) state_d = HOLD;
         end
         HOLD:    if (flush || !id_stall) state_d = REQ;
         DISCARD: if (mem_ack)            state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == REQ) || (state_q == DISCARD);
      imem_addr = (state_q == REQ) ? pc : req_addr_q;
      load_mem  = (state_q == REQ) && mem_ack && !id_stall && !flush;
      to_buf    = (state_q == REQ) && mem_ack && id_stall && !flush;
      load_buf  = (state_q == HOLD) && !id_stall && !flush;
      pc_write  = (flush || load_mem || load_buf) ? (`PC_REG_NPC) : ~(`PC_REG_NPC);
   end

   // In DISCARD the PC already holds the redirect target, so the stale address is replayed from req_addr_q
   always_comb begin
      req_addr_d  = imem_addr;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      id_valid_d  = id_valid_q;
      id_pc_d     = id_pc_q;
      id_pc4_d    = id_pc4_q;
      id_instr_d  = id_instr_q;
      if (to_buf) begin
         buf_pc_d    = pc;
         buf_instr_d = imem_rdata;
      end
      if (flush) begin
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
      end else if (load_mem) begin
         id_valid_d = 1'b1;
         id_pc_d    = pc;
         id_pc4_d   = pc + 32'd4;
         id_instr_d = imem_rdata;
      end else if (load_buf) begin
         id_valid_d = 1'b1;
         id_pc_d    = buf_pc_q;
         id_pc4_d   = buf_pc_q + 32'd4;
         id_instr_d = buf_instr_q;
      end else if ((state_q == REQ) && !mem_ack && !id_stall) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_addr_q  <= RESET_PC;
         buf_pc_q    <= RESET_PC;
         buf_instr_q <= NOP_INSTR;
         id_valid_q  <= 1'b0;
         id_pc_q     <= RESET_PC;
         id_pc4_q    <= RESET_PC + 32'd4;
         id_instr_q  <= NOP_INSTR;
      end else begin
         req_addr_q  <= req_addr_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         id_pc4_q    <= id_pc4_d;
         id_instr_q  <= id_instr_d;
      end
   end

   assign id_valid = id_valid_q;
   assign id_pc    = id_pc_q;
   assign id_pc4   = id_pc4_q;
   assign id_instr = id_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Random-stimulus bench for if_fetch_stage: PC register and variable-latency memory models,
// with an in-order expected instruction stream (restarted at each redirect) as scoreboard.
`ifndef PC_REG_NPC
`define PC_REG_NPC 1'b1
`endif

module tb_if_fetch_stage;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;

   logic        clock;
   logic        reset;
   logic [31:0] pc;
   logic        pc_write;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_instr;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   fetch_t      exp_q[$];
   logic [31:0] gen_pc;
   logic [31:0] npc_target;
   int          checks;
   int          errors;
   int          lat_max;
   int          stall_pct;
   int          flush_pct;
   bit          mem_busy;
   int          mem_lat;
   int          mem_cnt;
   logic [31:0] last_addr;

   bit          snap_ok;
   logic        snap_stall;
   logic        snap_flush;
   logic [31:0] snap_target;
   logic [31:0] snap_pc;

   logic        model_valid;
   logic [31:0] model_pc;
   logic [31:0] model_instr;

   if_fetch_stage #(
      .NOP_INSTR(NOP_INSTR),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .pc        (pc),
      .pc_write  (pc_write),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .id_stall  (id_stall),
      .flush     (flush),
      .id_valid  (id_valid),
      .id_pc     (id_pc),
      .id_pc4    (id_pc4),
      .id_instr  (id_instr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   // PC register: loads npc (sequential or redirect) only when the stage asks for it
   always @(posedge clock or negedge reset) begin
      if (!reset)                        pc <= RESET_PC;
      else if (pc_write == `PC_REG_NPC)  pc <= flush ? npc_target : pc + 32'd4;
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
      check_val({tag, "_id_instr"}, id_instr, NOP_INSTR);
      check_val({tag, "_id_pc"}, id_pc, RESET_PC);
      check_val({tag, "_id_pc4"}, id_pc4, RESET_PC + 32'd4);
      check_val({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
      check_val({tag, "_pc_write"}, {31'b0, pc_write}, {31'b0, ~(`PC_REG_NPC)});
   endtask

   task automatic reset_model();
      exp_q.delete();
      gen_pc      = RESET_PC;
      mem_busy    = 1'b0;
      model_valid = 1'b0;
      model_pc    = RESET_PC;
      model_instr = NOP_INSTR;
      id_stall    = 1'b0;
      flush       = 1'b0;
      imem_ack    = 1'b0;
      snap_ok     = 1'b0;
   endtask

   // One cycle of stimulus: memory response, stall/flush choice, expected-stream upkeep
   task automatic apply_stimulus();
      @(negedge clock);
      if (imem_req) begin
         if (!mem_busy) begin
            check_val("req_addr_is_pc", imem_addr, pc);
            mem_busy = 1'b1;
            mem_lat  = int'($urandom_range(0, lat_max));
            mem_cnt  = 0;
         end else begin
            check_val("req_addr_stable", imem_addr, last_addr);
         end
         last_addr  = imem_addr;
         imem_ack   = (mem_cnt >= mem_lat);
         imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
         if (imem_ack) mem_busy = 1'b0;
         else          mem_cnt++;
      end else begin
         if (mem_busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_held_until_ack: got req 0 expected 1 at %0t", $time);
            mem_busy = 1'b0;
         end
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
      end
      id_stall = ($urandom_range(0, 99) < stall_pct);
      flush    = ($urandom_range(0, 99) < flush_pct);
      if (flush) begin
         npc_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                  : 32'h0000_3100 + 32'(4 * $urandom_range(0, 63));
         exp_q.delete();
         gen_pc = npc_target;
      end else begin
         npc_target = $urandom;
      end
      while (exp_q.size() < 4) begin
         exp_q.push_back(fetch_t'{pc: gen_pc, instr: mem_word(gen_pc)});
         gen_pc = gen_pc + 32'd4;
      end
      snap_stall  = id_stall;
      snap_flush  = flush;
      snap_target = npc_target;
      snap_pc     = pc;
      snap_ok     = 1'b1;
   endtask

   // Judges the edge just taken against the inputs that were applied for it
   task automatic check_output();
      fetch_t e;
      if (snap_flush) begin
         check_val("flush_id_valid", {31'b0, id_valid}, 32'd0);
         check_val("flush_id_instr", id_instr, NOP_INSTR);
         check_val("flush_redirect_pc", pc, snap_target);
         model_valid = 1'b0;
         model_instr = NOP_INSTR;
      end else if (snap_stall) begin
         check_val("stall_pc_held", pc, snap_pc);
         check_val("stall_id_valid", {31'b0, id_valid}, {31'b0, model_valid});
         check_val("stall_id_pc", id_pc, model_pc);
         check_val("stall_id_pc4", id_pc4, model_pc + 32'd4);
         check_val("stall_id_instr", id_instr, model_instr);
      end else if (id_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL stream_underflow: got id_pc %h expected no delivery at %0t", id_pc, $time);
         end else begin
            e = exp_q.pop_front();
            check_val("deliver_id_pc", id_pc, e.pc);
            check_val("deliver_id_pc4", id_pc4, e.pc + 32'd4);
            check_val("deliver_id_instr", id_instr, e.instr);
            check_val("deliver_pc_advanced", pc, e.pc + 32'd4);
            model_valid = 1'b1;
            model_pc    = e.pc;
            model_instr = e.instr;
         end
      end else begin
         check_val("bubble_pc_held", pc, snap_pc);
         model_valid = 1'b0;
      end
   endtask

   always begin
      @(posedge clock);
      #1;
      if (snap_ok && reset) check_output();
   end

   task automatic run_phase(input int cycles, input int lat, input int stall, input int fl);
      lat_max   = lat;
      stall_pct = stall;
      flush_pct = fl;
      for (int i = 0; i < cycles; i++) apply_stimulus();
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      npc_target = 32'd0;
      imem_rdata = 32'd0;
      last_addr  = 32'd0;
      reset      = 1'b1;
      reset_model();
      #1 reset = 1'b0;
      #1 check_reset_values("init");
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Zero-wait memory, no stall: one instruction per cycle from 0x3000
      lat_max   = 0;
      stall_pct = 0;
      flush_pct = 0;
      for (int k = 0; k < 20; k++) apply_stimulus();
      check_val("zero_wait_pc", pc, RESET_PC + 32'd76);
      check_val("zero_wait_id_pc", id_pc, RESET_PC + 32'd72);
      check_val("zero_wait_id_valid", {31'b0, id_valid}, 32'd1);

      run_phase(150, 3, 25, 5);
      run_phase(150, 2, 50, 12);

      // Async reset pulse while a request is on the bus
      lat_max = 3;
      for (int k = 0; k < 20 && !imem_req; k++) apply_stimulus();
      #2 reset = 1'b0;
      snap_ok = 1'b0;
      #1 check_reset_values("midrst");
      reset_model();
      @(negedge clock);
      reset = 1'b1;

      run_phase(10, 0, 0, 0);
      run_phase(250, 3, 35, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
